seg_disp_scan: RTL
==================

// Module: seg_disp_scan
// PURPOSE
//  Time-multiplexed driver for an N-digit common-anode seven-segment display.
//  Generalises the two-digit writer: NUM_DIGITS channels, per-digit decimal point,
//  per-digit enable, 16-level brightness PWM, and an anti-ghost blanking gap.
//  Inputs are captured once per frame so a digit never shows a half-updated value.
//  Sits between the application datapath and the display pins.
// PARAMETERS
//  NUM_DIGITS    4     digits scanned, range 2..8
//  SLOT_CYCLES   4096  clk cycles per digit slot, >= BLANK_CYCLES+16
//  BLANK_CYCLES  64    cycles at slot start with all anodes off
//  SEG_ACT_LOW   1     1: seg_out/dp_out driven low to light
//  AN_ACT_LOW    0     1: anode driven low to enable
// PORTS
//  clk          in   1            system clock
//  reset        in   1            async active-low reset
//  values       in   4*NUM_DIGITS hex nibble per digit, digit i = values[4i+3:4i]
//  dp_in        in   NUM_DIGITS   decimal point request per digit
//  digit_en     in   NUM_DIGITS   1 = digit displayed, 0 = digit kept dark
//  brightness   in   4            duty level, 0 = 1/16 .. 15 = 16/16 of show window
//  seg_out      out  7            segments, bit0 = A .. bit6 = G
//  dp_out       out  1            decimal point segment
//  anodes       out  NUM_DIGITS   one-hot digit enable (polarity AN_ACT_LOW)
//  frame_start  out  1            one-cycle pulse when digit 0 slot begins
// BEHAVIOUR
//  - Reset (async assert, sync release): slot counter cnt=0, digit index idx=0,
//    shadow regs cleared, all anodes inactive, seg_out/dp_out inactive, frame_start=0.
//  - cnt counts 0..SLOT_CYCLES-1 and wraps; on wrap idx increments, wraps
//    NUM_DIGITS-1 -> 0. Reset mid-slot restarts at idx 0, cnt 0.
//  - Capture: when cnt==SLOT_CYCLES-1 && idx==NUM_DIGITS-1 (or first cycle after
//    reset) values, dp_in, digit_en, brightness latch into shadow regs. Input
//    changes at any other time invisible until next frame.
//  - FSM per slot: BLANK (cnt < BLANK_CYCLES): all anodes inactive, segs inactive.
//    SHOW (cnt >= BLANK_CYCLES): W = SLOT_CYCLES-BLANK_CYCLES, k = cnt-BLANK_CYCLES;
//    anode idx active iff shadow_en[idx] && (k*16 < W*(shadow_bright+1)).
//    Outside the PWM on-time, or if digit disabled, state behaves as BLANK.
//  - Segments follow the team hex decode (0-9, A,b,C,d,E,F); polarity per
//    SEG_ACT_LOW. dp_out = shadow_dp[idx] when anode active, else inactive.
//    Segments are forced inactive whenever no anode is active.
//  - All outputs registered: outputs reflect (cnt,idx) of the previous cycle,
//    fixed latency 1 clk; seg_out, dp_out, anodes change on the same edge.
//  - frame_start=1 on the output cycle corresponding to cnt==0 && idx==0.
//  - At most one anode active in any cycle; never two in consecutive cycles
//    (BLANK_CYCLES>=1 guaranteed by parameter check; elaboration error if not).
//  - brightness=15 -> on-time spans the full show window W.
// TESTING (NUM_DIGITS=4, SLOT_CYCLES=32, BLANK_CYCLES=4, SEG_ACT_LOW=1, AN_ACT_LOW=0)
//  1 reset low mid-scan, values=16'h1234 -> anodes=4'b0000, seg_out=7'h7F, dp_out=1
//    during reset; after release first frame_start pulse then digit 0 shows ~7'b0000110... wait
//    nibble 4 -> seg_out=~7'b1100110 with anodes=4'b0001 from cycle 5..32 of slot.
//  2 values=16'hF0A9, brightness=15, all enabled -> anodes sequence 0001,0010,0100,1000,
//    each active 28 cycles after 4 dark; seg_out = ~(9,A,0,F) decodes in order.
//  3 change values mid-frame 16'h1111 -> 16'h2222 at digit 2 -> digits 2,3 still
//    show 1 this frame; all show 2 from the next frame_start.
//  4 brightness=3, W=28 -> anode active 7 cycles per slot (k=0..6), dark otherwise.
//  5 digit_en=4'b1010, dp_in=4'b0010 -> only anodes 0010 and 1000 ever assert;
//    dp_out=0 only while anodes=0010.
//  6 continuous run 10 frames -> assert one-hot-or-zero anodes every cycle,
//    frame_start period exactly 128 cycles, no anode change without a blank cycle.
```

Note: test 1 contains a leftover draft fragment ("~7'b0000110... wait"). The corrected line is: after reset release, digit 0 shows nibble 4 → `seg_out=~7'b1100110`, `anodes=4'b0001` during cycles 5..32 of the slot.

Source files
------------

// File: rtl/seg_disp_scan.sv
// Time-multiplexed driver for an N-digit seven-segment display.
// Scans one digit per slot, with a blanking gap at the start of each slot
// and brightness PWM over the rest of it. Inputs are latched once per frame
// so a digit never shows a half-updated value. All outputs are registered.
module seg_disp_scan #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 4096,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          AN_ACT_LOW   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] values,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_start
);

  localparam int unsigned CW     = $clog2(SLOT_CYCLES);
  localparam int unsigned IW     = $clog2(NUM_DIGITS);
  localparam int unsigned PW     = CW + 5;
  localparam int unsigned SHOW_W = SLOT_CYCLES - BLANK_CYCLES;

  localparam logic [6:0]            SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACT_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACT_LOW ? '1 : '0;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_chk_digits
    $error("seg_disp_scan: NUM_DIGITS must be in 2..8");
  end
  if (BLANK_CYCLES < 1) begin : g_chk_blank
    $error("seg_disp_scan: BLANK_CYCLES must be at least 1");
  end
  if (SLOT_CYCLES < BLANK_CYCLES + 16) begin : g_chk_slot
    $error("seg_disp_scan: SLOT_CYCLES must be >= BLANK_CYCLES + 16");
  end

  typedef enum logic {
    BLANK,
    SHOW
  } slot_state_e;

  slot_state_e             state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    first_q;
  logic                    slot_end;
  logic                    capture;

  logic [4*NUM_DIGITS-1:0] sh_val_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q;
  logic [NUM_DIGITS-1:0]   sh_en_q;
  logic [3:0]              sh_bright_q;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;

  logic [PW-1:0]           k;
  logic                    on_time;
  logic                    lit;
  logic [3:0]              nib;
  logic [6:0]              glyph;

  assign slot_end = (cnt_q == CW'(SLOT_CYCLES - 1));
  assign capture  = first_q | (slot_end & (idx_q == IW'(NUM_DIGITS - 1)));

  // Slot counter, digit index and blank/show phase; the phase state stands
  // in for a cnt < BLANK_CYCLES compare and flips at the same slot positions.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    case (state_q)
      BLANK:   if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = SHOW;
      SHOW:    if (slot_end) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Next output values: PWM gate, digit select, hex decode and polarity.
  always_comb begin
    k       = PW'(cnt_q) - PW'(BLANK_CYCLES);
    on_time = (k << 4) < (PW'(SHOW_W) * (PW'(sh_bright_q) + PW'(1)));
    lit     = (state_q == SHOW) && sh_en_q[idx_q] && on_time;
    nib     = sh_val_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (lit) begin
      an_d[idx_q] = ~AN_ACT_LOW;
      seg_d       = SEG_ACT_LOW ? ~glyph : glyph;
      dp_d        = sh_dp_q[idx_q] ^ SEG_ACT_LOW;
    end
    fs_d = (cnt_q == '0) && (idx_q == '0);
  end

  // Scan position and phase registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= BLANK;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      first_q <= 1'b0;
    end
  end

  // Frame-boundary shadow copy of the display inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_en_q     <= '0;
      sh_bright_q <= '0;
    end else if (capture) begin
      sh_val_q    <= values;
      sh_dp_q     <= dp_in;
      sh_en_q     <= digit_en;
      sh_bright_q <= brightness;
    end
  end

  // Output registers, so segments, dp and anodes switch on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      an_q  <= AN_OFF;
      fs_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      fs_q  <= fs_d;
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign anodes      = an_q;
  assign frame_start = fs_q;

endmodule
